// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART FIFO: register map and default geometry.
package uart_fifo_pkg;

    localparam logic [1:0] UART_DATA_ADDR   = 2'b00;
    localparam logic [1:0] UART_STATUS_ADDR = 2'b01;
    localparam logic [1:0] UART_CTRL_ADDR   = 2'b10;
    localparam logic [1:0] UART_BRD_ADDR    = 2'b11;

    localparam int UART_DATA_W    = 9;
    localparam int UART_ADDR_LOG2 = 4;

endpackage

// File: rtl/uart_fifo_if.sv
// Bus/core side signal bundle of the UART FIFO.
interface uart_fifo_if
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int ADDR_LOG2 = UART_ADDR_LOG2
);

    logic                 BusStrobe;
    logic                 ChipSelect;
    logic [1:0]           Address;
    logic                 CoreStrobe;
    logic                 ClearOV;
    logic                 Flush;
    logic [ADDR_LOG2:0]   Threshold;
    logic [DATA_W-1:0]    DataIn;
    logic [DATA_W-1:0]    DataOut;
    logic [ADDR_LOG2:0]   Level;
    logic [ADDR_LOG2-1:0] ReadPtr;
    logic [ADDR_LOG2-1:0] WritePtr;
    logic                 Full;
    logic                 Empty;
    logic                 OV;
    logic                 AtThresh;

    modport master (
        output BusStrobe, ChipSelect, Address,
        output CoreStrobe, ClearOV, Flush,
        output Threshold, DataIn,
        input  DataOut, Level, ReadPtr, WritePtr,
        input  Full, Empty, OV, AtThresh
    );

    modport slave (
        input  BusStrobe, ChipSelect, Address,
        input  CoreStrobe, ClearOV, Flush,
        input  Threshold, DataIn,
        output DataOut, Level, ReadPtr, WritePtr,
        output Full, Empty, OV, AtThresh
    );

endinterface

// File: rtl/uart_strobe_edge.sv
// Rising-edge detector for the bus strobe, qualified by chip select and
// register offset so a held strobe yields exactly one event.
module uart_strobe_edge
    import uart_fifo_pkg::*;
#(
    parameter logic [1:0] MATCH_ADDR = UART_DATA_ADDR
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       strobe,
    input  logic       chip_select,
    input  logic [1:0] address,
    output logic       rise
);

    logic prev;
    logic armed;

    // armed stays low until the strobe is seen low after reset, so a
    // strobe still held at reset release never counts as an edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev <= strobe;
            if (!strobe)
                armed <= 1'b1;
        end
    end

    assign rise = strobe & ~prev & armed & chip_select
                & (address == MATCH_ADDR);

endmodule

// File: rtl/uart_fifo_p.sv
// Parametrised UART RX/TX FIFO with occupancy, watermark, flush and
// sticky overflow; storage and pointers live here.
module uart_fifo_p
    import uart_fifo_pkg::*;
#(
    parameter int         DATA_W        = UART_DATA_W,
    parameter int         ADDR_LOG2     = UART_ADDR_LOG2,
    parameter logic [1:0] DATA_ADDR     = UART_DATA_ADDR,
    parameter bit         BUS_SIDE_READ = 1'b1
) (
    input  logic      Clock,
    input  logic      Reset,
    uart_fifo_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_LOG2;
    localparam logic [ADDR_LOG2:0] DEPTH_L = {1'b1, {ADDR_LOG2{1'b0}}};

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [ADDR_LOG2-1:0] rd_ptr;
    logic [ADDR_LOG2-1:0] wr_ptr;
    logic [ADDR_LOG2:0]   level;
    logic                 ov;

    logic bus_evt;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic overflow;

    uart_strobe_edge #(
        .MATCH_ADDR (DATA_ADDR)
    ) u_edge (
        .Clock       (Clock),
        .Reset       (Reset),
        .strobe      (bus.BusStrobe),
        .chip_select (bus.ChipSelect),
        .address     (bus.Address),
        .rise        (bus_evt)
    );

    assign push = BUS_SIDE_READ ? bus.CoreStrobe : bus_evt;
    assign pop  = BUS_SIDE_READ ? bus_evt : bus.CoreStrobe;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // a pop from a full FIFO frees the slot for a same-cycle push
    assign do_pop   = pop & ~empty & ~bus.Flush;
    assign do_push  = push & (~full | do_pop) & ~bus.Flush;
    assign overflow = push & full & ~do_pop & ~bus.Flush;

    always_ff @(posedge Clock) begin
        if (do_push)
            mem[wr_ptr] <= bus.DataIn;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (bus.Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            ov <= 1'b0;
        else if (overflow)
            ov <= 1'b1;
        else if (bus.ClearOV)
            ov <= 1'b0;
    end

    assign bus.DataOut  = empty ? '0 : mem[rd_ptr];
    assign bus.Level    = level;
    assign bus.ReadPtr  = rd_ptr;
    assign bus.WritePtr = wr_ptr;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
    assign bus.OV       = ov;
    assign bus.AtThresh = (level >= bus.Threshold);

endmodule

// File: tb/tb_uart_fifo_p.sv
// Randomised self-checking bench for uart_fifo_p in RX and TX builds
// against a queue-based reference model.
module tb_uart_fifo_p;

    logic       Clock;
    logic       rst_rx;
    logic       rst_tx;
    logic       bs;
    logic       cs;
    logic [1:0] addr;
    logic       core;
    logic       clr;
    logic       flush;
    logic [4:0] thr;
    logic [8:0] din;

    int n_tests;
    int n_fail;

    uart_fifo_if #(.DATA_W(9), .ADDR_LOG2(4)) rx_if ();
    uart_fifo_if #(.DATA_W(8), .ADDR_LOG2(3)) tx_if ();

    assign rx_if.BusStrobe  = bs;
    assign rx_if.ChipSelect = cs;
    assign rx_if.Address    = addr;
    assign rx_if.CoreStrobe = core;
    assign rx_if.ClearOV    = clr;
    assign rx_if.Flush      = flush;
    assign rx_if.Threshold  = thr;
    assign rx_if.DataIn     = din;

    assign tx_if.BusStrobe  = bs;
    assign tx_if.ChipSelect = cs;
    assign tx_if.Address    = addr;
    assign tx_if.CoreStrobe = core;
    assign tx_if.ClearOV    = clr;
    assign tx_if.Flush      = flush;
    assign tx_if.Threshold  = thr[3:0];
    assign tx_if.DataIn     = din[7:0];

    uart_fifo_p #(
        .DATA_W        (9),
        .ADDR_LOG2     (4),
        .DATA_ADDR     (2'b00),
        .BUS_SIDE_READ (1'b1)
    ) dut_rx (
        .Clock (Clock),
        .Reset (rst_rx),
        .bus   (rx_if)
    );

    uart_fifo_p #(
        .DATA_W        (8),
        .ADDR_LOG2     (3),
        .DATA_ADDR     (2'b00),
        .BUS_SIDE_READ (1'b0)
    ) dut_tx (
        .Clock (Clock),
        .Reset (rst_tx),
        .bus   (tx_if)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // reference model state
    bit         tx_mode;
    int         depth;
    bit         bus_read;
    logic [8:0] mask;
    logic [8:0] q[$];
    int         rp;
    int         wp;
    bit         m_ov;
    bit         last_bs;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rp = 0;
        wp = 0;
        m_ov = 1'b0;
        // history before reset is treated as "strobe high"
        last_bs = 1'b1;
    endtask

    task automatic step();
        bit ev;
        bit psh;
        bit pp;
        bit dpop;
        bit dpush;
        int n;
        n = q.size();
        ev = bs && !last_bs && cs && (addr == 2'b00);
        last_bs = bs;
        psh = bus_read ? core : ev;
        pp  = bus_read ? ev : core;
        dpop = 1'b0;
        dpush = 1'b0;
        if (flush) begin
            q.delete();
            rp = 0;
            wp = 0;
        end else begin
            dpop  = pp && (n > 0);
            dpush = psh && ((n < depth) || dpop);
            if (dpop) begin
                void'(q.pop_front());
                rp = (rp + 1) % depth;
            end
            if (dpush) begin
                q.push_back(din & mask);
                wp = (wp + 1) % depth;
            end
        end
        if (!flush && psh && !dpush)
            m_ov = 1'b1;
        else if (clr)
            m_ov = 1'b0;
    endtask

    task automatic compare();
        logic [31:0] o_lvl, o_rp, o_wp, o_full, o_empty;
        logic [31:0] o_ov, o_at, o_do, e_do, t;
        int lvl;
        lvl = q.size();
        e_do = (lvl == 0) ? 32'h0 : 32'(q[0]);
        if (tx_mode) begin
            o_lvl   = 32'(tx_if.Level);
            o_rp    = 32'(tx_if.ReadPtr);
            o_wp    = 32'(tx_if.WritePtr);
            o_full  = 32'(tx_if.Full);
            o_empty = 32'(tx_if.Empty);
            o_ov    = 32'(tx_if.OV);
            o_at    = 32'(tx_if.AtThresh);
            o_do    = 32'(tx_if.DataOut);
            t       = 32'(thr[3:0]);
        end else begin
            o_lvl   = 32'(rx_if.Level);
            o_rp    = 32'(rx_if.ReadPtr);
            o_wp    = 32'(rx_if.WritePtr);
            o_full  = 32'(rx_if.Full);
            o_empty = 32'(rx_if.Empty);
            o_ov    = 32'(rx_if.OV);
            o_at    = 32'(rx_if.AtThresh);
            o_do    = 32'(rx_if.DataOut);
            t       = 32'(thr);
        end
        check("level", o_lvl, 32'(lvl));
        check("rptr", o_rp, 32'(rp));
        check("wptr", o_wp, 32'(wp));
        check("full", o_full, 32'(lvl == depth));
        check("empty", o_empty, 32'(lvl == 0));
        check("ov", o_ov, 32'(m_ov));
        check("atthresh", o_at, 32'(32'(lvl) >= t));
        check("dataout", o_do, e_do);
    endtask

    task automatic cycle();
        step();
        @(posedge Clock);
        #1;
        compare();
    endtask

    task automatic quiet();
        bs = 1'b0;
        core = 1'b0;
        clr = 1'b0;
        flush = 1'b0;
        cs = 1'b1;
        addr = 2'b00;
    endtask

    task automatic core_op(input logic [8:0] d);
        core = 1'b1;
        din = d;
        cycle();
        core = 1'b0;
    endtask

    task automatic bus_op(input logic [8:0] d, input int hold);
        bs = 1'b1;
        din = d;
        repeat (hold) cycle();
        bs = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        quiet();
        rst_rx = 1'b0;
        rst_tx = 1'b0;
        model_reset();
        @(posedge Clock);
        #1;
        compare();
        if (tx_mode)
            rst_tx = 1'b1;
        else
            rst_rx = 1'b1;
        cycle();
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int bias;
            bias = (i < cycles / 2) ? 75 : 30;
            bs    = ($urandom_range(0, 99) < 50);
            cs    = ($urandom_range(0, 7) != 0);
            addr  = ($urandom_range(0, 3) == 0)
                  ? 2'($urandom_range(0, 3)) : 2'b00;
            core  = ($urandom_range(0, 99) < bias);
            clr   = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 49) == 0);
            thr   = 5'($urandom_range(0, 31));
            din   = 9'($urandom);
            cycle();
        end
        quiet();
        cycle();
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        thr = 5'd0;
        din = '0;
        rst_rx = 1'b0;
        rst_tx = 1'b0;
        quiet();

        // RX build: core pushes, bus pops
        tx_mode = 1'b0;
        depth = 16;
        bus_read = 1'b1;
        mask = 9'h1FF;
        do_reset();
        check("rst_empty", 32'(rx_if.Empty), 32'd1);

        for (int i = 0; i < 16; i++)
            core_op(9'(9'h100 + i));
        check("fill_full", 32'(rx_if.Full), 32'd1);
        check("fill_wptr", 32'(rx_if.WritePtr), 32'd0);
        check("fill_head", 32'(rx_if.DataOut), 32'h100);

        core_op(9'h1AA);
        check("ovf_set", 32'(rx_if.OV), 32'd1);

        for (int i = 0; i < 5; i++)
            bus_op(9'h0, 3);
        check("pop5_head", 32'(rx_if.DataOut), 32'h105);
        check("pop5_level", 32'(rx_if.Level), 32'd11);

        for (int i = 0; i < 5; i++)
            core_op(9'(9'h110 + i));
        clr = 1'b1;
        cycle();
        clr = 1'b0;

        // push and pop together while full
        core = 1'b1;
        bs = 1'b1;
        din = 9'h155;
        cycle();
        core = 1'b0;
        bs = 1'b0;
        cycle();
        check("pp_level", 32'(rx_if.Level), 32'd16);

        // overflow and clear together: set wins
        core = 1'b1;
        clr = 1'b1;
        din = 9'h1EE;
        cycle();
        core = 1'b0;
        check("set_wins", 32'(rx_if.OV), 32'd1);
        cycle();
        clr = 1'b0;
        check("clr_alone", 32'(rx_if.OV), 32'd0);

        for (int i = 0; i < 15; i++)
            bus_op(9'h0, 1);
        check("last_entry", 32'(rx_if.DataOut), 32'h155);
        bus_op(9'h0, 1);

        bus_op(9'h0, 2);
        check("pop_empty", 32'(rx_if.Level), 32'd0);
        addr = 2'b01;
        bus_op(9'h0, 2);
        addr = 2'b00;
        core_op(9'h077);
        cs = 1'b0;
        bs = 1'b1;
        cycle();
        cs = 1'b1;
        cycle();
        cycle();
        bs = 1'b0;
        cycle();
        check("late_cs", 32'(rx_if.Level), 32'd1);

        for (int i = 0; i < 17; i++)
            core_op(9'($urandom));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_ov", 32'(rx_if.OV), 32'd1);

        thr = 5'd4;
        for (int i = 0; i < 6; i++) begin
            core_op(9'(i));
            check("thresh", 32'(rx_if.AtThresh), 32'(i >= 3));
        end
        core = 1'b1;
        flush = 1'b1;
        cycle();
        quiet();
        check("flush_push", 32'(rx_if.Level), 32'd0);

        random_phase(400);

        // TX build: bus pushes, core pops
        tx_mode = 1'b1;
        depth = 8;
        bus_read = 1'b0;
        mask = 9'h0FF;
        thr = 5'd8;
        do_reset();
        for (int i = 0; i < 9; i++)
            bus_op(9'(9'h0A0 + i), 2);
        check("tx_full", 32'(tx_if.Full), 32'd1);
        check("tx_ov", 32'(tx_if.OV), 32'd1);
        for (int i = 0; i < 8; i++)
            core_op(9'h0);
        check("tx_drained", 32'(tx_if.Empty), 32'd1);

        // reset pulsed in the middle of a held strobe
        bs = 1'b1;
        din = 9'h03C;
        cycle();
        cycle();
        #2;
        rst_tx = 1'b0;
        model_reset();
        #1;
        compare();
        @(posedge Clock);
        #1;
        compare();
        rst_tx = 1'b1;
        cycle();
        cycle();
        check("rst_no_write", 32'(tx_if.Level), 32'd0);
        bs = 1'b0;
        cycle();

        random_phase(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_p.md
Name: uart_fifo_p

Overview:
Parametrised receive/transmit FIFO for the UART IP, the successor to the fixed 9x16 RX FIFO.
- Width, depth and bus data address are generic.
- The rising-edge filtering of the bus strobe is built in and qualified by ChipSelect/Address, so a multi-cycle bus strobe moves exactly one word.
- Adds an occupancy count, a programmable watermark flag, a synchronous flush and a sticky overflow flag with defined set/clear priority.
- Sits between the UART serialiser/deserialiser and the Avalon-style register interface.

Parameters:
- DATA_W, 9, word width in bits (8 data + 1 framing/parity status).
- ADDR_LOG2, 4, log2 of depth; DEPTH = 2**ADDR_LOG2.
- DATA_ADDR, 2'b00, bus register offset that qualifies the bus strobe.
- BUS_SIDE_READ, 1: 1 = the bus strobe is the pop (RX use) and the core strobe is the push; 0 = the bus strobe is the push (TX use) and the core strobe is the pop.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- BusStrobe  in  1  bus read or write strobe; may stay high for several cycles.
- ChipSelect  in  1  bus chip select.
- Address  in  2  bus register offset.
- CoreStrobe  in  1  single-cycle push/pop from the UART core; used as-is, no edge filter.
- ClearOV  in  1  clears the overflow flag.
- Flush  in  1  synchronous empty.
- Threshold  in  ADDR_LOG2+1  watermark level.
- DataIn  in  DATA_W  write data.
- DataOut  out  DATA_W  head-of-queue data.
- Level  out  ADDR_LOG2+1  current occupancy, 0..DEPTH.
- ReadPtr  out  ADDR_LOG2  read pointer.
- WritePtr  out  ADDR_LOG2  write pointer.
- Full  out  1  Level == DEPTH.
- Empty  out  1  Level == 0.
- OV  out  1  sticky overflow flag.
- AtThresh  out  1  Level >= Threshold.

Behaviour:
- Reset (Reset low, asynchronous): ReadPtr=0, WritePtr=0, Level=0, OV=0, edge-detector history=0. Outputs then read Empty=1, Full=0, DataOut=0.
- Memory contents are not reset.
- Bus event: registered BusStrobe history with rise = BusStrobe & ~prev & ChipSelect & (Address==DATA_ADDR).
  - One event per rising edge; a strobe held N cycles gives 1 event.
  - If ChipSelect or Address is invalid on the rising cycle, there is no event and no event occurs later in that strobe.
- Push/pop mapping: push = bus event if BUS_SIDE_READ=0, else CoreStrobe. Pop = the other source.
- Push when not full: mem[WritePtr] <= DataIn; WritePtr increments mod DEPTH; Level increments.
- Push when full:
  - Without a same-cycle pop: data dropped, pointers and Level unchanged, OV <= 1.
  - With a same-cycle pop: both operations proceed, Level unchanged, no overflow.
- Pop when not empty: ReadPtr increments mod DEPTH; Level decrements.
- Pop when empty: ignored; no underflow flag; pointers unchanged.
- Simultaneous push and pop when empty: push only. The popped word is not lost because nothing was popped.
- DataOut = mem[ReadPtr], first-word-fall-through.
  - Valid whenever Empty=0.
  - Updates the cycle after a pop or after the first push into an empty FIFO.
  - When Empty=1, DataOut is a don't-care and is driven 0.
- Flush (synchronous): ReadPtr, WritePtr and Level go to 0. Any same-cycle push or pop is discarded. OV is unaffected.
- OV priority: an overflow event in the same cycle as ClearOV leaves OV=1 (set wins). Otherwise ClearOV clears OV next edge.
- AtThresh is combinational from Level and Threshold.
  - Threshold=0 gives AtThresh=1 always.
  - Threshold > DEPTH gives AtThresh=0 always.
- Latency: all flags and Level reflect an operation one cycle after the Clock edge that performs it. There is no bypass.
- Reset asserted mid-strobe: history is cleared, so a BusStrobe still high at reset release is not counted. A new rising edge is required.

Decomposition:
- Package uart_fifo_pkg:
  - Register offset constants (UART_DATA_ADDR=2'b00, UART_STATUS_ADDR=2'b01, UART_CTRL_ADDR=2'b10, UART_BRD_ADDR=2'b11).
  - Default DATA_W/ADDR_LOG2 constants.
- Sub-module uart_strobe_edge: registered edge detector with ChipSelect/Address qualification, one instance on BusStrobe.
- Storage and pointers stay in the top module.

Test Plan:
- Reset, then 16 core pushes of 0x100..0x10F → Level=16, Full=1, WritePtr=0 (wrapped), OV=0, DataOut=0x100.
- From full, one more core push of 0x1AA → OV=1, Level=16. Five bus pops each holding BusStrobe 3 cycles → exactly 5 pops, DataOut=0x105, Level=11.
- From full, core push and bus pop in the same cycle → Level stays 16, OV unchanged, the last entry read back equals the new DataIn. Then overflow plus ClearOV in the same cycle → OV=1; ClearOV alone next cycle → OV=0.
- From empty, bus pop → Level=0, ReadPtr=0. Bus strobe with Address=2'b01 → no pop. Strobe rising with ChipSelect=0, then ChipSelect=1 mid-strobe → no pop.
- Threshold=4 with pushes 0..5 → AtThresh rises on the 4th push. Flush while a push is asserted → Level=0, Empty=1, pointers=0, OV kept.
- DATA_W=8, ADDR_LOG2=3, BUS_SIDE_READ=0 (TX mode): 9 bus writes → Full after 8, OV=1. Core pops drain the FIFO in order. Reset pulsed low mid-strobe → all outputs reset and no write on release.
